// File: rtl/prog_byte_loader.sv
// Host byte-load receiver: synchronises the host write strobe, packs four bytes
// little-endian into a word and issues one single-cycle instruction-RAM write per word.
module prog_byte_loader #(
  parameter int ADDR_W      = 6,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [7:0]        data_in,
  input  logic              we_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic [1:0]        byte_idx,
  output logic              busy,
  output logic              full,
  output logic              overflow,
  output logic              frag_err
);
  // state   | meaning
  // IDLE    | no partial word pending, memory not full
  // COLLECT | partial word pending (byte_idx != 0)
  // FULL    | all words committed; strobes only raise overflow
  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

  localparam int              TW      = $clog2(TIMEOUT_CYC + 2);
  localparam logic [TW-1:0]   T_LIM   = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0]   T_ONE   = TW'(1);
  localparam logic [ADDR_W:0] WC_LAST = (ADDR_W+1)'((2**ADDR_W) - 1);
  localparam logic [ADDR_W:0] WC_ONE  = (ADDR_W+1)'(1);

  state_t        state;
  logic          s1, s2, s3;
  logic [23:0]   lanes;
  logic [TW-1:0] tcnt;
  logic          rise;

  assign rise = s2 & ~s3;
  assign busy = (byte_idx != 2'd0);
  assign full = (state == FULL);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state      <= IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      lanes      <= '0;
      tcnt       <= '0;
      byte_idx   <= 2'd0;
      word_count <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      overflow   <= 1'b0;
      frag_err   <= 1'b0;
    end else begin
      s1     <= we_in;
      s2     <= s1;
      s3     <= s2;
      mem_we <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (rise) begin
            tcnt     <= '0;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: lanes[7:0]   <= data_in;
              2'd1: lanes[15:8]  <= data_in;
              2'd2: lanes[23:16] <= data_in;
              default: begin
                // lane 3 is never stored; it goes straight into the word
                mem_we     <= 1'b1;
                mem_addr   <= word_count[ADDR_W-1:0];
                mem_wdata  <= {data_in, lanes};
                word_count <= word_count + WC_ONE;
              end
            endcase
            if (byte_idx == 2'd3)
              state <= (word_count == WC_LAST) ? FULL : IDLE;
            else
              state <= COLLECT;
          end else if (TIMEOUT_CYC > 0 && state == COLLECT) begin
            if (tcnt == T_LIM) begin
              byte_idx <= 2'd0;
              lanes    <= '0;
              frag_err <= 1'b1;
              tcnt     <= '0;
              state    <= IDLE;
            end else begin
              tcnt <= tcnt + T_ONE;
            end
          end else begin
            tcnt <= '0;
          end
        end
        FULL: begin
          if (rise) overflow <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
